reg_write_arbiter: RTL and testbench

- Shares one enable-register (the plain clocked register used throughout the BSV library RTL) between N write requesters.
- Round-robin arbitration, with an optional per-requester lock so one requester can own the register for multi-cycle read-modify-write sequences.
- A lock-timeout counter force-releases a lock that is held too long.
- Sits in the library RTL next to the register primitives; instantiated where generated code merges several rules writing one register.

---
 rtl/reg_write_arbiter_pkg.sv | 19 +
 rtl/reg_write_arbiter_rr_pick.sv | 29 ++
 rtl/reg_write_arbiter.sv | 108 ++++++++++
 tb/tb_reg_write_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register write arbiter and its round-robin picker.
package reg_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the pointer, with wrap.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shared enable-register with round-robin write arbitration, per-requester lock and lock timeout.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned       width    = 1,
  parameter logic [width-1:0]  init     = '0,
  parameter int unsigned       n_req    = 4,
  parameter int unsigned       lock_max = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [n_req-1:0]          REQ,
  input  logic [n_req-1:0]          LOCK,
  input  logic [n_req*width-1:0]    D_IN,
  output logic [n_req-1:0]          ACK,
  output logic [width-1:0]          Q_OUT,
  output logic [clog2(n_req)-1:0]   OWNER,
  output logic                      LOCKED,
  output logic                      LOCK_ABORT
);

  localparam int unsigned IW = clog2(n_req);
  localparam int unsigned CW = clog2(lock_max + 1);

  arb_state_e     state_q;
  logic [width-1:0] q_q;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  owner_q;
  logic [CW-1:0]  cnt_q;
  logic           abort_q;

  logic [n_req-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    wr_idx;
  logic [width-1:0] wr_data;

  rr_pick #(
    .N  (n_req),
    .IW (IW)
  ) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // While locked only the owner can be acknowledged; everyone else waits.
  always_comb begin
    ACK = '0;
    if (RST_N) begin
      if (state_q == ST_LOCKED) ACK[owner_q] = REQ[owner_q];
      else                      ACK = pick_gnt;
    end
  end

  assign wr_idx = (state_q == ST_LOCKED) ? owner_q : pick_idx;

  always_comb begin
    wr_data = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (wr_idx == IW'(i)) wr_data = D_IN[i*width +: width];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_q     <= init;
      state_q <= ST_IDLE;
      ptr_q   <= IW'(n_req - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (|ACK) q_q <= wr_data;
      if (state_q == ST_IDLE) begin
        if (pick_any) begin
          ptr_q   <= pick_idx;
          owner_q <= pick_idx;
          if (LOCK[pick_idx]) begin
            state_q <= ST_LOCKED;
            cnt_q   <= CW'(1);
          end
        end
      end else begin
        // A voluntary release takes precedence over the timeout check.
        if (!LOCK[owner_q]) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end else if (cnt_q == CW'(lock_max)) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          abort_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign Q_OUT      = q_q;
  assign OWNER      = owner_q;
  assign LOCKED     = (state_q == ST_LOCKED);
  assign LOCK_ABORT = abort_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: reference model predicts ACK and next-cycle outputs.
module tb_reg_write_arbiter;

  localparam int unsigned W    = 4;
  localparam int unsigned N    = 4;
  localparam int unsigned LM   = 4;
  localparam logic [3:0]  INIT = 4'h3;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [3:0]  LOCK;
  logic [15:0] D_IN;
  logic [3:0]  ACK;
  logic [3:0]  Q_OUT;
  logic [1:0]  OWNER;
  logic        LOCKED;
  logic        LOCK_ABORT;

  reg_write_arbiter #(
    .width    (W),
    .init     (INIT),
    .n_req    (N),
    .lock_max (LM)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ        (REQ),
    .LOCK       (LOCK),
    .D_IN       (D_IN),
    .ACK        (ACK),
    .Q_OUT      (Q_OUT),
    .OWNER      (OWNER),
    .LOCKED     (LOCKED),
    .LOCK_ABORT (LOCK_ABORT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] q;
    logic       lk;
    logic [1:0] own;
    logic       ab;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_abort = 0;
  logic [3:0] ack_seen;

  // Reference model state
  logic [3:0] m_q;
  logic       m_lk;
  int         m_ptr;
  int         m_own;
  int         m_cnt;
  logic       m_ab;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_ack(input logic rst, input logic [3:0] req);
    logic [3:0] a;
    a = '0;
    if (!rst) return a;
    if (m_lk) begin
      if (req[m_own]) a[m_own] = 1'b1;
      return a;
    end
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (req[c]) begin
        a[c] = 1'b1;
        return a;
      end
    end
    return a;
  endfunction

  task automatic cycle(input logic rst, input logic [3:0] req, input logic [3:0] lk,
                       input logic [15:0] din);
    logic [3:0] ea;
    int         gi;
    exp_t       e;
    exp_t       g;
    RST_N = rst;
    REQ   = req;
    LOCK  = lk;
    D_IN  = din;
    #1;
    ea = model_ack(rst, req);
    ack_seen = ACK;
    chk("ack", 16'(ACK), 16'(ea));
    gi = 0;
    for (int i = 0; i < 4; i++) if (ea[i]) gi = i;
    if (!rst) begin
      m_q = INIT; m_lk = 1'b0; m_ptr = 3; m_own = 0; m_cnt = 0; m_ab = 1'b0;
    end else begin
      m_ab = 1'b0;
      if (ea != 4'b0) m_q = din[gi*4 +: 4];
      if (!m_lk) begin
        if (ea != 4'b0) begin
          m_ptr = gi;
          m_own = gi;
          if (lk[gi]) begin m_lk = 1'b1; m_cnt = 1; end
        end
      end else if (!lk[m_own]) begin
        m_lk = 1'b0; m_cnt = 0;
      end else if (m_cnt == LM) begin
        m_lk = 1'b0; m_cnt = 0; m_ab = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    e.q = m_q; e.lk = m_lk; e.own = 2'(m_own); e.ab = m_ab;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    chk("q_out",  16'(Q_OUT),      16'(g.q));
    chk("locked", 16'(LOCKED),     16'(g.lk));
    chk("owner",  16'(OWNER),      16'(g.own));
    chk("abort",  16'(LOCK_ABORT), 16'(g.ab));
    if (LOCK_ABORT === 1'b1) n_abort++;
  endtask

  logic [3:0] rr_ack [5];
  logic [3:0] rr_q   [5];
  logic [3:0] q_hold;

  initial begin
    RST_N = 1'b0; REQ = '0; LOCK = '0; D_IN = '0;
    m_q = INIT; m_lk = 1'b0; m_ptr = 3; m_own = 0; m_cnt = 0; m_ab = 1'b0;
    rr_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_q   = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};

    // Reset with all requesting
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 4'b1111, 4'b0000, 16'hDCBA);
      chk("rst_ack", 16'(ack_seen), 16'h0);
    end
    chk("rst_q", 16'(Q_OUT), 16'(INIT));
    chk("rst_locked", 16'(LOCKED), 16'h0);

    // Round-robin fairness
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'b1111, 4'b0000, 16'hDCBA);
      chk("rr_ack", 16'(ack_seen), 16'(rr_ack[i]));
      chk("rr_q", 16'(Q_OUT), 16'(rr_q[i]));
    end

    // Lock hold by requester 2
    cycle(1'b1, 4'b0100, 4'b0100, 16'h0500);
    chk("lk_entry", 16'(LOCKED), 16'h1);
    chk("lk_q5", 16'(Q_OUT), 16'h5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'b1111, 4'b0100, {4'hF, 4'(6 + i), 4'hE, 4'hD});
      chk("lk_only2", 16'(ack_seen), 16'h4);
      chk("lk_q", 16'(Q_OUT), 16'(6 + i));
    end
    cycle(1'b1, 4'b1111, 4'b0000, 16'hF9ED);
    chk("lk_rel_ack", 16'(ack_seen), 16'h4);
    chk("lk_rel_q", 16'(Q_OUT), 16'h9);
    chk("lk_rel_noabort", 16'(LOCK_ABORT), 16'h0);
    cycle(1'b1, 4'b1111, 4'b0000, 16'h1234);
    chk("lk_next3", 16'(ack_seen), 16'h8);

    // Lock held without writing
    cycle(1'b1, 4'b0010, 4'b0010, 16'h00E0);
    q_hold = Q_OUT;
    chk("nw_q", 16'(q_hold), 16'hE);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'b0000, 4'b0010, 16'h5555);
      chk("nw_ack", 16'(ack_seen), 16'h0);
      chk("nw_q_hold", 16'(Q_OUT), 16'(q_hold));
      chk("nw_locked", 16'(LOCKED), 16'h1);
      chk("nw_owner", 16'(OWNER), 16'h1);
    end
    cycle(1'b1, 4'b0000, 4'b0000, 16'h5555);

    // Lock timeout on requester 0
    n_abort = 0;
    cycle(1'b1, 4'b0001, 4'b0001, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'b1111, 4'b0001, 16'h4327);
      chk("to_ack0", 16'(ack_seen), 16'h1);
      chk("to_abort", 16'(LOCK_ABORT), (i == 3) ? 16'h1 : 16'h0);
      chk("to_locked", 16'(LOCKED), (i == 3) ? 16'h0 : 16'h1);
    end
    cycle(1'b1, 4'b1111, 4'b0001, 16'h4327);
    chk("to_next1", 16'(ack_seen), 16'h2);
    chk("to_pulse_end", 16'(LOCK_ABORT), 16'h0);
    chk("to_abort_cnt", 16'(n_abort), 16'h1);
    cycle(1'b1, 4'b0000, 4'b0000, 16'h0000);

    // Reset while locked
    cycle(1'b1, 4'b0100, 4'b0100, 16'h0800);
    cycle(1'b1, 4'b0100, 4'b0100, 16'h0900);
    chk("rl_locked_pre", 16'(LOCKED), 16'h1);
    cycle(1'b0, 4'b1111, 4'b0100, 16'hABCD);
    chk("rl_locked", 16'(LOCKED), 16'h0);
    chk("rl_abort", 16'(LOCK_ABORT), 16'h0);
    chk("rl_q", 16'(Q_OUT), 16'(INIT));
    cycle(1'b1, 4'b1111, 4'b0000, 16'hABCD);
    chk("rl_first0", 16'(ack_seen), 16'h1);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      cycle(($urandom_range(0, 24) != 0), 4'($urandom), 4'($urandom), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
